// File: rtl/imm_pkg.sv
// imm_pkg: immediate format codes and the opcodes used to auto-decode the format.
package imm_pkg;
    localparam logic [2:0] IMM_I   = 3'b000;
    localparam logic [2:0] IMM_S   = 3'b001;
    localparam logic [2:0] IMM_B   = 3'b010;
    localparam logic [2:0] IMM_U   = 3'b011;
    localparam logic [2:0] IMM_J   = 3'b100;
    localparam logic [2:0] IMM_Z   = 3'b101;
    localparam logic [2:0] IMM_ILL = 3'b111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
endpackage

// File: rtl/imm_fmt_decode.sv
// imm_fmt_decode: maps opcode (and funct3[2] for SYSTEM) to an immediate format code.
module imm_fmt_decode
    import imm_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic       funct3_msb,
    output logic [2:0] fmt
);
    always_comb begin
        fmt = (opcode == OP_SYSTEM) ? (funct3_msb ? IMM_Z : IMM_I) :
              (opcode == OP_LOAD || opcode == OP_IMM ||
               opcode == OP_IMM32 || opcode == OP_JALR) ? IMM_I :
              (opcode == OP_STORE)  ? IMM_S :
              (opcode == OP_BRANCH) ? IMM_B :
              (opcode == OP_LUI || opcode == OP_AUIPC) ? IMM_U :
              (opcode == OP_JAL)    ? IMM_J : IMM_ILL;
    end
endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered RV immediate generator with a one-deep valid/ready output stage.
// Define IMM_GEN_AUTO_FMT_EN to decode the format from the opcode instead of imm_src.
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [2:0]      imm_src,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_illegal
);
    logic [2:0]  fmt;
    logic [31:0] imm32;
    logic        s;
`ifdef IMM_GEN_AUTO_FMT_EN
    imm_fmt_decode u_dec (
        .opcode    (instr[6:0]),
        .funct3_msb(instr[14]),
        .fmt       (fmt)
    );
    logic unused_src;
    assign unused_src = ^imm_src;
`else
    assign fmt = imm_src;
    logic unused_op;
    assign unused_op = ^instr[6:0];
`endif
    assign s = instr[31];
    always_comb begin
        imm32 = (fmt == IMM_I) ? {{20{s}}, instr[31:20]} :
                (fmt == IMM_S) ? {{20{s}}, instr[31:25], instr[11:7]} :
                (fmt == IMM_B) ? {{20{s}}, instr[7], instr[30:25], instr[11:8], 1'b0} :
                (fmt == IMM_U) ? {instr[31:12], 12'b0} :
                (fmt == IMM_J) ? {{12{s}}, instr[19:12], instr[20], instr[30:21], 1'b0} :
                (fmt == IMM_Z) ? {27'b0, instr[19:15]} : 32'b0;
    end
    assign in_ready = !out_valid || out_ready;
    // Every legal 32-bit result is already correctly signed, so widening to XLEN is a plain sign extension.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid   <= 1'b0;
            out_imm     <= '0;
            out_fmt     <= '0;
            out_illegal <= 1'b0;
        end else if (in_valid && in_ready) begin
            out_valid   <= 1'b1;
            out_imm     <= XLEN'($signed(imm32));
            out_fmt     <= fmt;
            out_illegal <= (fmt > IMM_Z);
        end else if (out_ready) begin
            out_valid   <= 1'b0;
        end
    end
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: scoreboard bench for imm_gen_pipe; the XLEN=64 auto-format checks run when IMM_GEN_AUTO_FMT_EN is defined.
module tb_imm_gen_pipe;
`ifdef IMM_GEN_AUTO_FMT_EN
    localparam int XLEN = 64;
`else
    localparam int XLEN = 32;
`endif
    typedef struct {
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            ill;
    } exp_t;

    logic            clk = 0;
    logic            reset = 0;
    logic            in_valid = 0;
    logic            in_ready;
    logic [31:0]     instr = 0;
    logic [2:0]      imm_src = 0;
    logic            out_valid;
    logic            out_ready = 0;
    logic [XLEN-1:0] out_imm;
    logic [2:0]      out_fmt;
    logic            out_illegal;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];
    exp_t e;

    imm_gen_pipe #(.XLEN(XLEN)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .imm_src(imm_src), .out_valid(out_valid), .out_ready(out_ready),
        .out_imm(out_imm), .out_fmt(out_fmt), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    task automatic push(input logic [XLEN-1:0] imm, input logic [2:0] f, input logic ill);
        exp_t x;
        x.imm = imm;
        x.fmt = f;
        x.ill = ill;
        sb.push_back(x);
    endtask

    task automatic test_reset;
        reset = 0;
        repeat (2) @(negedge clk);
        checks++;
        if ({out_valid, out_illegal, out_fmt} !== 5'b0 || out_imm !== '0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: valid=%b ill=%b fmt=%b imm=%h rdy=%b, want all 0 and rdy=1",
                     out_valid, out_illegal, out_fmt, out_imm, in_ready);
        end
        reset = 1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL after_reset: valid=%b rdy=%b, want 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_i_type;
        out_ready = 1;
        in_valid = 1; instr = 32'hFFF00093; imm_src = 3'b000;
        push('1, 3'b000, 1'b0);
        @(negedge clk);
        in_valid = 0;
        e = sb.pop_front();
        checks++;
        if (out_valid !== 1'b1 || out_imm !== e.imm || out_fmt !== e.fmt || out_illegal !== e.ill) begin
            errors++;
            $display("FAIL i_type: valid=%b imm=%h fmt=%b ill=%b, want 1 %h %b %b",
                     out_valid, out_imm, out_fmt, out_illegal, e.imm, e.fmt, e.ill);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL i_type_drain: valid=%b, want 0", out_valid);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] vi [4] = '{32'hFE20AE23, 32'h00000463, 32'h123452B7, 32'hFFDFF0EF};
        logic [2:0]  vs [4] = '{3'b001, 3'b010, 3'b011, 3'b100};
        logic [31:0] ve [4] = '{32'hFFFFFFFC, 32'h00000008, 32'h12345000, 32'hFFFFFFFC};
        out_ready = 1;
        for (int i = 0; i <= 4; i++) begin
            if (i > 0) begin
                e = sb.pop_front();
                checks++;
                if (out_valid !== 1'b1 || out_imm !== e.imm || out_fmt !== e.fmt || out_illegal !== e.ill) begin
                    errors++;
                    $display("FAIL b2b[%0d]: valid=%b imm=%h fmt=%b ill=%b, want 1 %h %b %b",
                             i - 1, out_valid, out_imm, out_fmt, out_illegal, e.imm, e.fmt, e.ill);
                end
            end
            if (i < 4) begin
                in_valid = 1; instr = vi[i]; imm_src = vs[i];
                push(XLEN'(ve[i]), vs[i], 1'b0);
                #1;
                checks++;
                if (in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_ready[%0d]: in_ready=%b, want 1", i, in_ready);
                end
            end else begin
                in_valid = 0;
            end
            @(negedge clk);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain: valid=%b, want 0", out_valid);
        end
    endtask

    task automatic test_backpressure;
        out_ready = 1;
        in_valid = 1; instr = 32'hFFF00093; imm_src = 3'b000;
        push('1, 3'b000, 1'b0);
        @(negedge clk);
        out_ready = 0;
        instr = 32'h123452B7; imm_src = 3'b011;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_imm !== sb[0].imm) begin
                errors++;
                $display("FAIL stall[%0d]: rdy=%b valid=%b imm=%h, want 0 1 %h",
                         i, in_ready, out_valid, out_imm, sb[0].imm);
            end
            @(negedge clk);
        end
        out_ready = 1;
        #1;
        e = sb.pop_front();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_imm !== e.imm) begin
            errors++;
            $display("FAIL release: rdy=%b valid=%b imm=%h, want 1 1 %h", in_ready, out_valid, out_imm, e.imm);
        end
        push(XLEN'(32'h12345000), 3'b011, 1'b0);
        @(negedge clk);
        in_valid = 0;
        e = sb.pop_front();
        checks++;
        if (out_valid !== 1'b1 || out_imm !== e.imm || out_fmt !== e.fmt) begin
            errors++;
            $display("FAIL after_release: valid=%b imm=%h fmt=%b, want 1 %h %b",
                     out_valid, out_imm, out_fmt, e.imm, e.fmt);
        end
        @(negedge clk);
    endtask

    task automatic test_illegal_z;
        logic [2:0]  vs [3] = '{3'b110, 3'b101, 3'b111};
        logic [31:0] ve [3] = '{32'h0, 32'h0000001F, 32'h0};
        logic        vl [3] = '{1'b1, 1'b0, 1'b1};
        out_ready = 1;
        for (int i = 0; i <= 3; i++) begin
            if (i > 0) begin
                e = sb.pop_front();
                checks++;
                if (out_valid !== 1'b1 || out_imm !== e.imm || out_fmt !== e.fmt || out_illegal !== e.ill) begin
                    errors++;
                    $display("FAIL ill_z[%0d]: valid=%b imm=%h fmt=%b ill=%b, want 1 %h %b %b",
                             i - 1, out_valid, out_imm, out_fmt, out_illegal, e.imm, e.fmt, e.ill);
                end
            end
            if (i < 3) begin
                in_valid = 1; instr = 32'hFFFFFFFF; imm_src = vs[i];
                push(XLEN'(ve[i]), vs[i], vl[i]);
            end else begin
                in_valid = 0;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_full;
        out_ready = 0;
        in_valid = 1; instr = 32'hFFF00093; imm_src = 3'b000;
        @(negedge clk);
        in_valid = 0;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL full_before_reset: valid=%b, want 1", out_valid);
        end
        #2 reset = 0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_imm !== '0 || out_fmt !== 3'b0 || out_illegal !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL async_reset: valid=%b imm=%h fmt=%b ill=%b rdy=%b, want 0 0 0 0 1",
                     out_valid, out_imm, out_fmt, out_illegal, in_ready);
        end
        @(negedge clk);
        reset = 1;
        @(negedge clk);
    endtask

`ifdef IMM_GEN_AUTO_FMT_EN
    task automatic test_auto_fmt;
        logic [31:0] vi [3] = '{32'hFFF00093, 32'h00000000, 32'h800002B7};
        out_ready = 1;
        push('1, 3'b000, 1'b0);
        push('0, 3'b111, 1'b1);
        push(64'hFFFFFFFF80000000, 3'b011, 1'b0);
        for (int i = 0; i <= 3; i++) begin
            if (i > 0) begin
                e = sb.pop_front();
                checks++;
                if (out_valid !== 1'b1 || out_imm !== e.imm || out_fmt !== e.fmt || out_illegal !== e.ill) begin
                    errors++;
                    $display("FAIL auto[%0d]: valid=%b imm=%h fmt=%b ill=%b, want 1 %h %b %b",
                             i - 1, out_valid, out_imm, out_fmt, out_illegal, e.imm, e.fmt, e.ill);
                end
            end
            if (i < 3) begin
                in_valid = 1; instr = vi[i]; imm_src = 3'b011;
            end else begin
                in_valid = 0;
            end
            @(negedge clk);
        end
    endtask
`endif

    initial begin
        test_reset();
`ifdef IMM_GEN_AUTO_FMT_EN
        test_auto_fmt();
`else
        test_i_type();
        test_back_to_back();
        test_backpressure();
        test_illegal_z();
`endif
        test_reset_full();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
